mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates one shared memory port between instruction fetch and data (MEM stage) accesses.
// Latency: request seen in IDLE at cycle N -> m_req at N+1 -> done pulse at N+2 with zero wait states.
// Backpressure: m_ready low holds the grant indefinitely; requesters see stall until their done pulse.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_DSTREAK = 2
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  // data side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  // shared memory port
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  // pipeline stalls
  output logic              if_stall,
  output logic              d_stall
);

  // +2 keeps the counter at least one bit wide even when MAX_DSTREAK is 0
  localparam int SW = $clog2(MAX_DSTREAK + 2);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              win_d_q, win_d_d;     // 1: current/last grant belongs to the data side
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_any;
  logic pick_d;

  assign d_any  = d_read | d_write;
  // data wins unless it has already taken MAX_DSTREAK grants in a row over a waiting fetch
  assign pick_d = d_any & ((streak_q < STREAK_MAX) | ~if_req);

  // Next-state, grant capture, streak and read-data capture
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    win_d_d    = win_d_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d   = GRANT_D;
          win_d_d   = 1'b1;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          // a simultaneous read+write is treated as a store
          m_we_d    = d_write;
          if (if_req && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (if_req) begin
          state_d   = GRANT_I;
          win_d_d   = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_we_d    = 1'b0;
          streak_d  = '0;
        end
      end
      GRANT_I: begin
        if (m_ready) begin
          state_d    = RESP;
          if_rdata_d = m_rdata;
        end
      end
      GRANT_D: begin
        if (m_ready) begin
          state_d = RESP;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // no fetch waiting means no starvation to track
    if (!if_req) begin
      streak_d = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      win_d_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      win_d_q    <= win_d_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = (state_q == RESP) && !win_d_q;
  assign d_done   = (state_q == RESP) &&  win_d_q;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_any & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed self-checking bench for mem_port_arbiter.
// Latency: checks the 1-cycle grant / 1-cycle response timing and wait-state stretching.
// Backpressure: drives m_ready low to hold grants and checks stall/done behaviour.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        if_stall;
  logic        d_stall;

  int n_vec;
  int n_err;

  mem_port_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .MAX_DSTREAK(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_done (if_done),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .if_stall(if_stall),
    .d_stall (d_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one cycle and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_req  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    int       n_grant;
    logic     order [6];
    logic     exp_order [6];

    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ready = 1'b0;

    // ---- reset state
    step();
    step();
    check("rst_m_req",    {31'd0, m_req},   32'd0);
    check("rst_m_we",     {31'd0, m_we},    32'd0);
    check("rst_m_addr",   m_addr,           32'd0);
    check("rst_m_wdata",  m_wdata,          32'd0);
    check("rst_if_rdata", if_rdata,         32'd0);
    check("rst_d_rdata",  d_rdata,          32'd0);
    check("rst_if_done",  {31'd0, if_done}, 32'd0);
    check("rst_d_done",   {31'd0, d_done},  32'd0);
    rst = 1'b1;
    step();

    // ---- fetch only, zero wait states
    if_req = 1'b1; if_addr = 32'h40; m_ready = 1'b1; m_rdata = 32'h2008000A;
    #1;
    check("f_if_stall_req", {31'd0, if_stall}, 32'd1);
    step();
    check("f_m_req",   {31'd0, m_req},   32'd1);
    check("f_m_addr",  m_addr,           32'h40);
    check("f_m_we",    {31'd0, m_we},    32'd0);
    check("f_if_done_early", {31'd0, if_done}, 32'd0);
    step();
    check("f_if_done",  {31'd0, if_done},  32'd1);
    check("f_if_rdata", if_rdata,          32'h2008000A);
    check("f_if_stall", {31'd0, if_stall}, 32'd0);
    check("f_m_req_resp", {31'd0, m_req},  32'd0);
    if_req = 1'b0;
    m_rdata = 32'hBAD0BAD0;   // must be ignored outside a grant
    step();
    step();
    check("f_if_done_once", {31'd0, if_done}, 32'd0);
    check("f_rdata_hold",   if_rdata,         32'h2008000A);

    // ---- simultaneous fetch and load: data goes first
    if_req = 1'b1; if_addr = 32'h44;
    d_read = 1'b1; d_addr = 32'h100;
    m_ready = 1'b1; m_rdata = 32'h11111111;
    step();
    check("s_m_addr_d", m_addr,          32'h100);
    check("s_m_we",     {31'd0, m_we},   32'd0);
    step();
    check("s_d_done",   {31'd0, d_done},  32'd1);
    check("s_if_done0", {31'd0, if_done}, 32'd0);
    check("s_d_rdata",  d_rdata,          32'h11111111);
    check("s_if_stall", {31'd0, if_stall}, 32'd1);
    d_read = 1'b0; m_rdata = 32'h22222222;
    step();
    step();
    check("s_m_addr_i", m_addr,          32'h44);
    check("s_m_req_i",  {31'd0, m_req},  32'd1);
    step();
    check("s_if_done",  {31'd0, if_done}, 32'd1);
    check("s_if_rdata", if_rdata,         32'h22222222);
    check("s_d_rdata_hold", d_rdata,      32'h11111111);
    if_req = 1'b0;
    step();
    step();

    // ---- starvation bound: D, D, I, D, D, I
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    order = '{default: 1'b0};
    if_req = 1'b1; if_addr = 32'h40;
    d_read = 1'b1; d_addr = 32'h100;
    m_ready = 1'b1; m_rdata = 32'h33333333;
    n_grant = 0;
    for (int c = 0; c < 40 && n_grant < 6; c++) begin
      step();
      if (m_req) begin
        order[n_grant] = (m_addr == 32'h100);
        n_grant++;
      end
    end
    check("st_grants", n_grant, 32'd6);
    for (int g = 0; g < 6; g++) begin
      check($sformatf("st_order%0d", g), {31'd0, order[g]}, {31'd0, exp_order[g]});
    end
    // requests drop while the last (fetch) grant is live: it must still complete
    idle_all();
    m_ready = 1'b1;
    step();
    check("st_drop_if_done", {31'd0, if_done}, 32'd1);
    check("st_d_rdata",      d_rdata,          32'h33333333);
    m_ready = 1'b0;
    step();
    step();

    // ---- store with three wait states
    d_write = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    m_ready = 1'b0; m_rdata = 32'h44444444;
    step();
    for (int w = 0; w < 4; w++) begin
      if (w == 3) m_ready = 1'b1;
      check($sformatf("w_m_req%0d", w),   {31'd0, m_req},   32'd1);
      check($sformatf("w_m_we%0d", w),    {31'd0, m_we},    32'd1);
      check($sformatf("w_m_wdata%0d", w), m_wdata,          32'hDEADBEEF);
      check($sformatf("w_m_addr%0d", w),  m_addr,           32'h8);
      check($sformatf("w_d_stall%0d", w), {31'd0, d_stall}, 32'd1);
      step();
    end
    check("w_d_done",  {31'd0, d_done},  32'd1);
    check("w_d_stall", {31'd0, d_stall}, 32'd0);
    check("w_d_rdata", d_rdata,          32'h33333333);
    idle_all();
    step();
    step();

    // ---- read and write together behave as a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'hC; d_wdata = 32'h12345678;
    m_ready = 1'b1; m_rdata = 32'h55555555;
    step();
    check("rw_m_we",    {31'd0, m_we}, 32'd1);
    check("rw_m_wdata", m_wdata,       32'h12345678);
    step();
    check("rw_d_done",  {31'd0, d_done}, 32'd1);
    check("rw_d_rdata", d_rdata,         32'h33333333);
    idle_all();
    step();
    step();

    // ---- reset in the middle of a fetch grant
    if_req = 1'b1; if_addr = 32'h80; m_ready = 1'b0;
    step();
    check("r_m_req1", {31'd0, m_req}, 32'd1);
    step();
    check("r_m_req2", {31'd0, m_req}, 32'd1);
    rst = 1'b0; m_ready = 1'b1; m_rdata = 32'h66666666;
    step();
    check("r_m_req_off", {31'd0, m_req},   32'd0);
    check("r_if_done",   {31'd0, if_done}, 32'd0);
    check("r_if_rdata",  if_rdata,         32'd0);
    check("r_m_addr",    m_addr,           32'd0);
    rst = 1'b1; if_req = 1'b0; m_ready = 1'b0;
    step();
    check("r_if_done2", {31'd0, if_done}, 32'd0);
    check("r_m_req3",   {31'd0, m_req},   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
